// File: rtl/snake_input_ctrl.sv
// Input stage of the snake core: button synchronise/debounce, start acknowledge,
// two-deep direction request queue with reversal rejection, and the game-speed step tick.
module snake_input_ctrl #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned TICK_CYCLES = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnC,
  input  logic       Run,
  output logic       Step,
  output logic [1:0] Next_Dir,
  output logic       Ack,
  output logic [1:0] Pending
);

  localparam int unsigned NumBtn = 5;
  localparam int unsigned IdxL   = 0;
  localparam int unsigned IdxR   = 1;
  localparam int unsigned IdxU   = 2;
  localparam int unsigned IdxD   = 3;
  localparam int unsigned IdxC   = 4;

  localparam int unsigned DebW  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TickW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_CYCLES - 1);

  localparam logic [1:0] DirLeft  = 2'b00;
  localparam logic [1:0] DirRight = 2'b01;
  localparam logic [1:0] DirUp    = 2'b10;
  localparam logic [1:0] DirDown  = 2'b11;

  // ---------------------------------------------------------------------------
  // Synchronise and debounce
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] level_q, level_d;
  logic [NumBtn-1:0] press_q, press_d;
  logic [DebW-1:0]   deb_cnt_q [NumBtn];
  logic [DebW-1:0]   deb_cnt_d [NumBtn];
  logic              ack_q;

  assign btn_raw = {BtnC, BtnD, BtnU, BtnR, BtnL};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      level_d[i]   = level_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DebMax) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Only rising edges of the debounced level are events; releases are ignored.
  assign press_d = level_d & ~level_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      level_q <= '0;
      press_q <= '0;
      ack_q   <= 1'b0;
      for (int i = 0; i < NumBtn; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      press_q <= press_d;
      ack_q   <= press_q[IdxC];
      for (int i = 0; i < NumBtn; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Direction request selection (L > R > U > D)
  // ---------------------------------------------------------------------------
  logic       req_valid;
  logic [1:0] req_dir;

  always_comb begin
    req_valid = press_q[IdxL] | press_q[IdxR] | press_q[IdxU] | press_q[IdxD];
    req_dir   = DirLeft;
    if (press_q[IdxL]) begin
      req_dir = DirLeft;
    end else if (press_q[IdxR]) begin
      req_dir = DirRight;
    end else if (press_q[IdxU]) begin
      req_dir = DirUp;
    end else if (press_q[IdxD]) begin
      req_dir = DirDown;
    end
  end

  // ---------------------------------------------------------------------------
  // Step tick and request queue
  // ---------------------------------------------------------------------------
  logic [TickW-1:0] tick_q, tick_d;
  logic             step_q, step_d;
  logic [1:0]       next_dir_q, next_dir_d;
  logic [1:0]       entry_q [2];
  logic [1:0]       entry_d [2];
  logic [1:0]       count_q, count_d;

  logic       pop, push;
  logic [1:0] count_ap, tail_ap, dir_ap, ref_dir;

  always_comb begin
    step_d = Run && (tick_q == TickMax);
    pop    = step_d && (count_q != 2'd0);

    // Queue view after any same-cycle pop; the reference direction is taken from it.
    count_ap = count_q - {1'b0, pop};
    tail_ap  = (pop || (count_q == 2'd2)) ? entry_q[1] : entry_q[0];
    dir_ap   = pop ? entry_q[0] : next_dir_q;
    ref_dir  = (count_ap != 2'd0) ? tail_ap : dir_ap;

    push = Run && req_valid && (count_ap != 2'd2) &&
           (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b01));

    entry_d[0] = pop ? entry_q[1] : entry_q[0];
    entry_d[1] = entry_q[1];
    if (push) begin
      if (count_ap == 2'd0) begin
        entry_d[0] = req_dir;
      end else begin
        entry_d[1] = req_dir;
      end
    end

    count_d    = count_ap + {1'b0, push};
    next_dir_d = dir_ap;
    tick_d     = (tick_q == TickMax) ? '0 : tick_q + 1'b1;

    if (!Run) begin
      tick_d     = '0;
      count_d    = 2'd0;
      next_dir_d = DirRight;
      entry_d[0] = DirLeft;
      entry_d[1] = DirLeft;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tick_q     <= '0;
      step_q     <= 1'b0;
      next_dir_q <= DirRight;
      entry_q[0] <= DirLeft;
      entry_q[1] <= DirLeft;
      count_q    <= 2'd0;
    end else begin
      tick_q     <= tick_d;
      step_q     <= step_d;
      next_dir_q <= next_dir_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
      count_q    <= count_d;
    end
  end

  assign Step     = step_q;
  assign Next_Dir = next_dir_q;
  assign Ack      = ack_q;
  assign Pending  = count_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: two instances (slow-debounce/fast-tick and
// fast-debounce/slow-tick) share stimulus; Ack and Step events are scoreboarded.
module tb_snake_input_ctrl;

  localparam int unsigned DebA  = 16;
  localparam int unsigned TickA = 8;
  localparam int unsigned DebB  = 4;
  localparam int unsigned TickB = 64;

  localparam logic [4:0] BL = 5'b00001;
  localparam logic [4:0] BR = 5'b00010;
  localparam logic [4:0] BU = 5'b00100;
  localparam logic [4:0] BD = 5'b01000;
  localparam logic [4:0] BC = 5'b10000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn   = '0;
  logic       run   = 1'b0;

  logic       step_a, ack_a, step_b, ack_b;
  logic [1:0] dir_a, pend_a, dir_b, pend_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_a  = 1'b0;

  typedef struct packed {
    logic [1:0] dir;
    logic [1:0] pend;
  } step_exp_t;

  typedef struct {
    logic [4:0] m0;
    logic [4:0] m1;
    logic [4:0] m2;
    logic [1:0] pend;
    logic [1:0] dir;
    logic [1:0] pend_after;
    string      name;
  } dir_vec_t;

  int        ack_a_q[$];
  int        ack_b_q[$];
  int        step_a_q[$];
  step_exp_t step_b_q[$];
  dir_vec_t  vecs[7];

  snake_input_ctrl #(.DEB_CYCLES(DebA), .TICK_CYCLES(TickA)) u_dut_a (
    .Clk(clk), .Reset(rst_n), .BtnL(btn[0]), .BtnR(btn[1]), .BtnU(btn[2]), .BtnD(btn[3]),
    .BtnC(btn[4]), .Run(run), .Step(step_a), .Next_Dir(dir_a), .Ack(ack_a), .Pending(pend_a)
  );

  snake_input_ctrl #(.DEB_CYCLES(DebB), .TICK_CYCLES(TickB)) u_dut_b (
    .Clk(clk), .Reset(rst_n), .BtnL(btn[0]), .BtnR(btn[1]), .BtnU(btn[2]), .BtnD(btn[3]),
    .BtnC(btn[4]), .Run(run), .Step(step_b), .Next_Dir(dir_b), .Ack(ack_b), .Pending(pend_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Hold a button mask for `hold` cycles, then idle until `gap` cycles have passed.
  task automatic press(input logic [4:0] mask, input int hold, input int gap);
    int k = cyc;
    if (mask[4] && hold >= DebA) ack_a_q.push_back(k + DebA + 3);
    if (mask[4] && hold >= DebB) ack_b_q.push_back(k + DebB + 3);
    btn = mask;
    repeat (hold) next();
    btn = '0;
    repeat (gap - hold) next();
  endtask

  task automatic wait_b(input int bound);
    int n = 0;
    while (step_b_q.size() != 0 && n < bound) begin
      next();
      n++;
    end
    check("step_b_timeout", step_b_q.size(), 0);
  endtask

  // Output monitors: every observed Ack/Step must match the next scoreboard entry.
  always @(negedge clk) begin
    if (ack_a) begin
      if (ack_a_q.size() == 0) check("ack_a_spurious", ack_a, 1'b0);
      else check("ack_a_cycle", cyc, ack_a_q.pop_front());
    end
    if (ack_b) begin
      if (ack_b_q.size() == 0) check("ack_b_spurious", ack_b, 1'b0);
      else check("ack_b_cycle", cyc, ack_b_q.pop_front());
    end
    if (mon_a && step_a) begin
      if (step_a_q.size() == 0) check("step_a_spurious", step_a, 1'b0);
      else begin
        check("step_a_cycle", cyc, step_a_q.pop_front());
        check("step_a_dir", dir_a, 2'b01);
      end
    end
    if (step_b) begin
      if (step_b_q.size() == 0) check("step_b_spurious", step_b, 1'b0);
      else begin
        step_exp_t e;
        e = step_b_q.pop_front();
        check("step_b_dir", dir_b, e.dir);
        check("step_b_pend", pend_b, e.pend);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    vecs[0] = '{m0:BL, m1:BU, m2:BD, pend:2'd1, dir:2'b10, pend_after:2'd0, name:"lud"};
    vecs[1] = '{m0:BU, m1:BL, m2:5'd0, pend:2'd2, dir:2'b10, pend_after:2'd1, name:"ul"};
    vecs[2] = '{m0:BR, m1:BR, m2:5'd0, pend:2'd0, dir:2'b01, pend_after:2'd0, name:"rr"};
    vecs[3] = '{m0:BD, m1:BR, m2:BU, pend:2'd2, dir:2'b11, pend_after:2'd1, name:"dru"};
    vecs[4] = '{m0:BL|BU, m1:5'd0, m2:5'd0, pend:2'd0, dir:2'b01, pend_after:2'd0,
                name:"lu_same"};
    vecs[5] = '{m0:BU|BD, m1:5'd0, m2:5'd0, pend:2'd1, dir:2'b10, pend_after:2'd0,
                name:"ud_same"};
    vecs[6] = '{m0:BU, m1:BD, m2:BL, pend:2'd2, dir:2'b10, pend_after:2'd1, name:"udl"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_step_a", step_a, 1'b0);
    check("rst_ack_a", ack_a, 1'b0);
    check("rst_dir_a", dir_a, 2'b01);
    check("rst_pend_a", pend_a, 2'd0);
    check("rst_step_b", step_b, 1'b0);
    check("rst_ack_b", ack_b, 1'b0);
    check("rst_dir_b", dir_b, 2'b01);
    check("rst_pend_b", pend_b, 2'd0);
    rst_n = 1'b1;
    next();

    // Ack: long hold acknowledges once, short glitch only passes the fast debouncer
    press(BC, 40, 70);
    press(BC, 5, 30);

    // Step cadence on the fast-tick instance
    mon_a = 1'b1;
    r     = cyc;
    run   = 1'b1;
    for (int i = 1; i <= 5; i++) step_a_q.push_back(r + int'(TickA) * i);
    repeat (44) next();
    run = 1'b0;
    check("step_a_missing", step_a_q.size(), 0);
    next();
    mon_a = 1'b0;
    next();

    // Direction request table
    for (int v = 0; v < 7; v++) begin
      run = 1'b1;
      press(vecs[v].m0, 6, 14);
      press(vecs[v].m1, 6, 14);
      press(vecs[v].m2, 6, 14);
      check({vecs[v].name, "_pend"}, pend_b, vecs[v].pend);
      step_b_q.push_back('{dir:vecs[v].dir, pend:vecs[v].pend_after});
      wait_b(80);
      run = 1'b0;
      next();
      next();
      check({vecs[v].name, "_flush_pend"}, pend_b, 2'd0);
      check({vecs[v].name, "_flush_dir"}, dir_b, 2'b01);
      check({vecs[v].name, "_flush_step"}, step_b, 1'b0);
    end

    // Full queue U,L; a D request lands on the same edge as the step pop
    run = 1'b1;
    r   = cyc;
    press(BU, 6, 14);
    press(BL, 6, 14);
    check("full_pend", pend_b, 2'd2);
    while (cyc < r + int'(TickB) - int'(DebB) - 3) next();
    step_b_q.push_back('{dir:2'b10, pend:2'd2});
    step_b_q.push_back('{dir:2'b00, pend:2'd1});
    step_b_q.push_back('{dir:2'b11, pend:2'd0});
    press(BD, 6, 6);
    wait_b(200);
    run = 1'b0;
    next();
    next();

    // Simultaneous L and U with Next_Dir=UP: only L is queued
    run = 1'b1;
    step_b_q.push_back('{dir:2'b10, pend:2'd0});
    press(BU, 6, 14);
    wait_b(80);
    press(BL | BU, 6, 14);
    check("lu_up_pend", pend_b, 2'd1);
    step_b_q.push_back('{dir:2'b00, pend:2'd0});
    wait_b(80);
    run = 1'b0;
    next();
    next();

    // Run drop flushes a full queue; reset mid-debounce clears everything
    run = 1'b1;
    press(BU, 6, 14);
    press(BL, 6, 14);
    check("drop_pend_before", pend_b, 2'd2);
    run = 1'b0;
    next();
    run = 1'b1;
    check("drop_pend", pend_b, 2'd0);
    check("drop_dir", dir_b, 2'b01);
    btn = BC;
    repeat (4) next();
    rst_n = 1'b0;
    btn   = '0;
    run   = 1'b0;
    #1;
    check("mid_rst_pend_b", pend_b, 2'd0);
    check("mid_rst_dir_b", dir_b, 2'b01);
    check("mid_rst_step_b", step_b, 1'b0);
    check("mid_rst_ack_b", ack_b, 1'b0);
    check("mid_rst_dir_a", dir_a, 2'b01);
    repeat (3) next();
    rst_n = 1'b1;
    repeat (25) next();
    // Exactly DEB cycles of press after reset must still produce a full-latency Ack
    press(BC, 4, 20);

    check("ack_a_missing", ack_a_q.size(), 0);
    check("ack_b_missing", ack_b_q.size(), 0);
    check("step_b_left", step_b_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
